line_fill_word_sequencer: RTL and testbench

Parametrised, sequential successor to the cache word-select and set-enable decoders. It accepts a cache line-fill request carrying a set index and a word offset. It then steps a one-hot word select across every word of the line, one word per returned memory beat, and holds a one-hot set enable for the whole fill. It sits between the cache controller's miss path and the data-array write ports. It also tracks which words have arrived so the controller can restart early.

---
 rtl/line_fill_word_sequencer.sv | 122 ++++++++++++
 tb/tb_line_fill_word_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/line_fill_word_sequencer.sv
// line_fill_word_sequencer: steps a one-hot word select across a cache line fill, one word per memory beat.
// Optional macro CRIT_WORD_FIRST_EN: start at the requested word instead of word 0.  Rev 1.0
`default_nettype none

module line_fill_word_sequencer #(
  parameter int OFFSET_W = 3,
  parameter int SET_W    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SET_W-1:0]        start_set,
  input  logic [OFFSET_W-1:0]     start_offset,
  input  logic                    mem_valid,
  output logic                    ready,
  output logic                    busy,
  output logic                    beat_we,
  output logic [2**OFFSET_W-1:0]  word_select,
  output logic [2**SET_W-1:0]     set_enable,
  output logic                    crit_beat,
  output logic [2**OFFSET_W-1:0]  filled_mask,
  output logic                    done
);

  localparam int WORDS = 2**OFFSET_W;
  localparam int SETS  = 2**SET_W;
  localparam logic [WORDS-1:0]  ONE_W     = {{(WORDS-1){1'b0}}, 1'b1};
  localparam logic [SETS-1:0]   ONE_S     = {{(SETS-1){1'b0}}, 1'b1};
  localparam logic [OFFSET_W:0] LAST_BEAT = (OFFSET_W+1)'(WORDS-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [OFFSET_W-1:0] ptr, ptr_n, ptr_inc, ptr_load;
  logic [OFFSET_W-1:0] saved_off, saved_off_n;
  logic [OFFSET_W:0]   count, count_n;
  logic [WORDS-1:0]    word_select_n, filled_mask_n;
  logic [SETS-1:0]     set_enable_n;

`ifdef CRIT_WORD_FIRST_EN
  assign ptr_load = start_offset;
`else
  assign ptr_load = '0;
`endif

  assign ptr_inc   = ptr + OFFSET_W'(1);
  assign ready     = (state == S_IDLE);
  assign busy      = (state == S_FILL);
  assign done      = (state == S_DONE);
  assign beat_we   = mem_valid & busy;
  assign crit_beat = beat_we & (ptr == saved_off);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      count       <= '0;
      saved_off   <= '0;
      word_select <= '0;
      set_enable  <= '0;
      filled_mask <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      count       <= count_n;
      saved_off   <= saved_off_n;
      word_select <= word_select_n;
      set_enable  <= set_enable_n;
      filled_mask <= filled_mask_n;
    end
  end

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    count_n       = count;
    saved_off_n   = saved_off;
    word_select_n = word_select;
    set_enable_n  = set_enable;
    filled_mask_n = filled_mask;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n       = S_FILL;
          saved_off_n   = start_offset;
          ptr_n         = ptr_load;
          count_n       = '0;
          filled_mask_n = '0;
          word_select_n = ONE_W << ptr_load;
          set_enable_n  = ONE_S << start_set;
        end
      end
      S_FILL: begin
        if (mem_valid) begin
          filled_mask_n = filled_mask | word_select;
          ptr_n         = ptr_inc;
          count_n       = count + (OFFSET_W+1)'(1);
          word_select_n = ONE_W << ptr_inc;
          // Selects drop to zero as soon as the last word is written.
          if (count == LAST_BEAT) begin
            state_n       = S_DONE;
            word_select_n = '0;
            set_enable_n  = '0;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_line_fill_word_sequencer.sv
// Bench for line_fill_word_sequencer: directed fills plus random traffic against a beat-order model.
`default_nettype none

module tb_line_fill_word_sequencer;

  localparam int OFFSET_W = 3;
  localparam int SET_W    = 6;
  localparam int WORDS    = 8;
  localparam int SETS     = 64;

  logic                clk = 1'b0;
  logic                reset, start, mem_valid;
  logic [SET_W-1:0]    start_set;
  logic [OFFSET_W-1:0] start_offset;
  logic                ready, busy, beat_we, crit_beat, done;
  logic [WORDS-1:0]    word_select, filled_mask;
  logic [SETS-1:0]     set_enable;

  line_fill_word_sequencer #(.OFFSET_W(OFFSET_W), .SET_W(SET_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_set(start_set),
    .start_offset(start_offset), .mem_valid(mem_valid), .ready(ready),
    .busy(busy), .beat_we(beat_we), .word_select(word_select),
    .set_enable(set_enable), .crit_beat(crit_beat),
    .filled_mask(filled_mask), .done(done)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 filling, 2 done; beats taken so far and the word order they follow.
  int               m_state = 0;
  int               m_set = 0, m_off = 0, m_first = 0, m_k = 0;
  logic [WORDS-1:0] m_mask = '0;
  int               passed = 0, total = 0;

  function automatic int pos(input int k);
    return (m_first + k) % WORDS;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic step(input bit rs, input bit st, input int set, input int off,
                      input bit mv, input bit do_chk);
    bit   fill, we;
    logic [63:0] ws_exp, se_exp;
    @(negedge clk);
    reset        = rs;
    start        = st;
    start_set    = set[SET_W-1:0];
    start_offset = off[OFFSET_W-1:0];
    mem_valid    = mv;
    #1;
    fill   = (m_state == 1);
    we     = fill && mv;
    ws_exp = fill ? (64'd1 << pos(m_k)) : 64'd0;
    se_exp = fill ? (64'd1 << m_set) : 64'd0;
    if (do_chk) begin
      chk("ready", ready, m_state == 0);
      chk("busy", busy, fill);
      chk("beat_we", beat_we, we);
      chk("word_select", word_select, ws_exp);
      chk("set_enable", set_enable, se_exp);
      chk("crit_beat", crit_beat, we && (pos(m_k) == m_off));
      chk("filled_mask", filled_mask, m_mask);
      chk("done", done, m_state == 2);
    end
    if (rs) begin
      m_state = 0; m_k = 0; m_mask = '0;
    end else if (m_state == 0) begin
      if (st) begin
        m_state = 1; m_set = set % SETS; m_off = off % WORDS; m_k = 0; m_mask = '0;
`ifdef CRIT_WORD_FIRST_EN
        m_first = m_off;
`else
        m_first = 0;
`endif
      end
    end else if (m_state == 1) begin
      if (mv) begin
        m_mask[pos(m_k)] = 1'b1;
        m_k++;
        if (m_k == WORDS) m_state = 2;
      end
    end else begin
      m_state = 0;
    end
  endtask

  // stall=1 inserts two idle cycles after each beat; illegal=1 holds start high with another set.
  task automatic do_fill(input int set, input int off, input bit stall, input bit illegal);
    int c;
    step(0, 1, set, off, 0, 1);
    c = 0;
    while (m_state != 0 && c < 64) begin
      step(0, illegal, (set + 1) % SETS, (off + 1) % WORDS, stall ? (c % 3 == 0) : 1'b1, 1);
      c++;
    end
    step(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_valid = 1'b0; start_set = '0; start_offset = '0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);

    do_fill(5, 0, 0, 0);
    do_fill(9, 6, 0, 0);
    do_fill(17, 3, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    do_fill(63, 2, 0, 1);
    do_fill(5, 5, 0, 0);

    // Abandon a fill after three beats, then refill normally.
    step(0, 1, 40, 4, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    do_fill(41, 7, 0, 0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 60) == 0), ($urandom_range(0, 2) == 0),
           $urandom_range(0, SETS-1), $urandom_range(0, WORDS-1),
           $urandom_range(0, 1), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
